rom_dump: RTL and testbench
===========================

# rom_dump

Readback engine for the 16-bit instruction memory. On a start command it reads a block of words from the memory's synchronous read port and emits each word as two bytes, high byte first, over a valid/ready byte stream toward the UART transmitter. The byte order is the exact inverse of the byte-pair loader, so a dumped image can be reloaded unchanged. It sits between the instruction-memory read port and the debug UART TX path.

## Interface
- AW, 16, address width of the memory and of `base_addr`/`mem_addr`
- DW, 16, memory word width; fixed at 16, two bytes per word
- LW, 16, width of the `length` word-count input
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  AW  first word address, latched at accepted start
- length  in  LW  number of words to dump, latched at accepted start
- mem_addr  out  AW  read address to memory (registered)
- mem_en  out  1  read enable, high only in RD
- mem_rdata  in  DW  memory read data, valid the cycle after `mem_en`
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  byte available
- tx_ready  in  1  transmitter accepts byte
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the block finishes

## Operation
- States: IDLE, RD, LAT, HI, LO, DONE.
- IDLE:
  - On `start`=1 and `length`!=0: latch `addr_q`=`base_addr` and `cnt_q`=`length`, then go to RD.
  - On `start`=1 and `length`=0: go directly to DONE.
  - On `start`=0: remain in IDLE.
- RD: `mem_en`=1, `mem_addr`=`addr_q`; next state LAT.
- LAT: capture `word_q`=`mem_rdata`; next state HI.
- HI: `tx_valid`=1, `tx_data`=`word_q[15:8]`; on `tx_ready` go to LO, otherwise hold.
- LO: `tx_valid`=1, `tx_data`=`word_q[7:0]`; on `tx_ready`:
  - If `cnt_q`==1, go to DONE.
  - Otherwise `cnt_q`-=1, `addr_q`+=1 (modulo 2^AW; 0xFFFF wraps to 0x0000), and go to RD.
- DONE: `done`=1 for one cycle; next state IDLE.
- `start` outside IDLE is ignored, with no queuing.
- `tx_data` is stable whenever `tx_valid`=1 and only changes after the handshake. `tx_valid` never drops without `tx_ready`.
- All outputs derive from registers only. There is no combinational path from `tx_ready` or `start` to any output.
- `tx_data` is 0x00 outside HI/LO.

## Timing
- Reset (`rst_n`=0 at a clk edge) forces the following. This applies in any state, including mid-transfer, which aborts it with no `done` pulse.
  - state IDLE
  - `addr_q`=0, `cnt_q`=0, `word_q`=0
  - `mem_addr`=0, `mem_en`=0
  - `tx_valid`=0, `tx_data`=0x00
  - `busy`=0, `done`=0
- Start accepted at edge T:
  - RD during cycle T+1.
  - Data captured at the end of cycle T+2.
  - First `tx_valid` in cycle T+3.
- With `tx_ready` held at 1, throughput is 4 cycles per word (RD, LAT, HI, LO).
- For N words with no backpressure, `done` is high in cycle T+4N+1.
- For `length`=0, `done` is high in cycle T+1.
- `busy`=1 from T+1 through the DONE cycle inclusive.
- Memory read latency is exactly one cycle. `mem_rdata` is not sampled outside LAT.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with random inputs -> all outputs 0 and state IDLE. Release `rst_n` with `start`=0 -> outputs stay 0.
- Single word: mem[0x0005]=0x1234, start with `base_addr`=5, `length`=1, `tx_ready`=1 -> `mem_addr`=5 with `mem_en` in T+1; bytes 0x12 then 0x34 in T+3 and T+4; `done` in T+5; `busy` low in T+6.
- Backpressure: mem[0x10..0x12]=0xA1B2, 0xC3D4, 0xE5F6, `length`=3, `tx_ready` toggling randomly -> byte stream A1 B2 C3 D4 E5 F6 in order; `tx_data` stable while valid and not ready; exactly one `done` pulse.
- Wrap and zero length:
  - `base_addr`=0xFFFF, `length`=2 -> reads addresses 0xFFFF then 0x0000.
  - `length`=0 -> no `tx_valid`; `done` in T+1.
- Abort and ignored start:
  - `rst_n`=0 while in LO of word 2 -> next cycle IDLE with `tx_valid`=0 and no `done`.
  - `start` pulsed while `busy` -> the latched `addr_q`/`cnt_q` are unchanged and the transfer completes normally.
- Round trip: dump a 64-word image through the loader-format byte stream into a scoreboard -> the reassembled words equal memory contents.

Source files
------------

// File: rtl/rom_dump.sv
// rom_dump: reads a block of 16-bit memory words and streams them as high/low byte pairs.
module rom_dump #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] length,
  output logic [AW-1:0] mem_addr,
  output logic          mem_en,
  input  logic [DW-1:0] mem_rdata,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic          done
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] LAT  = 3'd2;
  localparam logic [2:0] HI   = 3'd3;
  localparam logic [2:0] LO   = 3'd4;
  localparam logic [2:0] DONE = 3'd5;
  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] word_q, word_d;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = (length == '0) ? DONE : RD;
        addr_d  = (length == '0) ? addr_q : base_addr;
        cnt_d   = (length == '0) ? cnt_q : length;
      end
      RD:   state_d = LAT;
      LAT:  begin
        word_d  = mem_rdata;
        state_d = HI;
      end
      HI:   state_d = tx_ready ? LO : HI;
      LO:   if (tx_ready) begin
        state_d = (cnt_q == LW'(1)) ? DONE : RD;
        cnt_d   = (cnt_q == LW'(1)) ? cnt_q : cnt_q - LW'(1);
        addr_d  = (cnt_q == LW'(1)) ? addr_q : addr_q + AW'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end
  // Outputs are pure decodes of flopped state, so tx_ready/start never reach them.
  assign mem_addr = addr_q;
  assign mem_en   = (state_q == RD);
  assign tx_valid = (state_q == HI) || (state_q == LO);
  assign tx_data  = (state_q == HI) ? word_q[DW-1:DW-8] : (state_q == LO) ? word_q[7:0] : 8'h00;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
endmodule

// File: tb/tb_rom_dump.sv
// tb_rom_dump: randomized self-checking bench for rom_dump against a byte-stream reference model.
module tb_rom_dump;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic [15:0] base_addr = 0;
  logic [15:0] length = 0;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic [15:0] mem_rdata = 0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 0;
  logic        busy;
  logic        done;
  int vectors = 0;
  int errors = 0;
  logic [15:0] mem [0:65535];
  logic [7:0]  got_b[$];
  int          got_cyc[$];
  logic [15:0] rd_a[$];
  int          rd_cyc[$];
  logic [7:0]  exp_b[$];
  int done_cyc, done_cnt, first_valid;

  rom_dump #(.AW(16), .DW(16), .LW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_rdata(mem_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory; returns junk when not enabled so stray sampling shows up.
  always @(posedge clk) mem_rdata <= mem_en ? mem[mem_addr] : 16'($urandom);

  // Reference: the dump is simply each word of the block, high byte then low byte.
  function automatic void build_expect(input logic [15:0] base, input int len);
    logic [15:0] a;
    exp_b = {};
    for (int i = 0; i < len; i++) begin
      a = base + 16'(i);
      exp_b.push_back(mem[a][15:8]);
      exp_b.push_back(mem[a][7:0]);
    end
  endfunction

  task automatic run_dump(input logic [15:0] base, input logic [15:0] len, input int rdy_pct, input int poke);
    bit pv, pr;
    logic [7:0] pd;
    got_b = {}; got_cyc = {}; rd_a = {}; rd_cyc = {};
    done_cyc = 0; done_cnt = 0; first_valid = 0; pv = 0; pr = 0; pd = 0;
    @(posedge clk); #1;
    base_addr = base; length = len; start = 1; tx_ready = 0;
    for (int k = 1; k <= 20 * int'(len) + 50; k++) begin
      @(posedge clk); #1;
      start = (k == poke);
      if (k == poke) begin base_addr = base + 16'h80; length = len + 16'd3; end
      tx_ready = ($urandom_range(99) < rdy_pct);
      if (pv && !pr) begin
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== pd) begin
          errors++;
          $display("FAIL hold_stable cycle %0d: valid=%b data=%h, required valid=1 data=%h", k, tx_valid, tx_data, pd);
        end
      end
      if (done === 1'b1) begin done_cnt++; if (done_cyc == 0) done_cyc = k; end
      vectors++;
      if (busy !== 1'(done_cyc == 0 || k <= done_cyc)) begin
        errors++;
        $display("FAIL busy cycle %0d: got %b, required %b", k, busy, (done_cyc == 0 || k <= done_cyc));
      end
      if (mem_en === 1'b1) begin rd_a.push_back(mem_addr); rd_cyc.push_back(k); end
      if (tx_valid === 1'b1 && first_valid == 0) first_valid = k;
      if (tx_valid === 1'b1 && tx_ready) begin got_b.push_back(tx_data); got_cyc.push_back(k); end
      pv = tx_valid; pr = tx_ready; pd = tx_data;
      if (done_cyc != 0 && k == done_cyc + 2) break;
    end
    start = 0; tx_ready = 0;
    vectors++;
    if (done_cyc == 0) begin errors++; $display("FAIL done_timeout: no done pulse, required one"); end
  endtask

  task automatic test_reset;
    rst_n = 0;
    for (int k = 0; k < 4; k++) begin
      start = k < 2 ? 1'($urandom) : 1'b0;
      base_addr = 16'($urandom); length = 16'($urandom); tx_ready = 1'($urandom);
      if (k == 2) rst_n = 1;
      @(posedge clk); #1;
      vectors++;
      if ({mem_addr, mem_en, tx_data, tx_valid, busy, done} !== '0) begin
        errors++;
        $display("FAIL reset_outputs step %0d: got addr=%h en=%b data=%h valid=%b busy=%b done=%b, required all 0",
                 k, mem_addr, mem_en, tx_data, tx_valid, busy, done);
      end
    end
    tx_ready = 0;
  endtask

  task automatic test_single_word;
    mem[16'h0005] = 16'h1234;
    run_dump(16'h0005, 16'd1, 100, 0);
    vectors++;
    if (rd_a.size() != 1 || rd_a[0] !== 16'h0005 || rd_cyc[0] != 1) begin
      errors++; $display("FAIL single_read: %0d reads, first addr/cycle %h/%0d, required 1 read of 0005 in cycle 1",
                         rd_a.size(), rd_a.size() ? rd_a[0] : 16'hx, rd_cyc.size() ? rd_cyc[0] : -1);
    end
    vectors++;
    if (got_b.size() != 2 || got_b[0] !== 8'h12 || got_b[1] !== 8'h34 || got_cyc[0] != 3 || got_cyc[1] != 4) begin
      errors++; $display("FAIL single_bytes: got %0d bytes (%p at %p), required 12,34 in cycles 3,4", got_b.size(), got_b, got_cyc);
    end
    vectors++;
    if (done_cyc != 5 || done_cnt != 1) begin
      errors++; $display("FAIL single_done: cycle %0d count %0d, required cycle 5 count 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_backpressure;
    mem[16'h0010] = 16'hA1B2; mem[16'h0011] = 16'hC3D4; mem[16'h0012] = 16'hE5F6;
    build_expect(16'h0010, 3);
    run_dump(16'h0010, 16'd3, 50, 0);
    vectors++;
    if (got_b.size() != exp_b.size()) begin
      errors++; $display("FAIL bp_count: got %0d bytes, required %0d", got_b.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      vectors++;
      if (got_b[i] !== exp_b[i]) begin errors++; $display("FAIL bp_byte[%0d]: got %h, required %h", i, got_b[i], exp_b[i]); end
    end
    vectors++;
    if (done_cnt != 1) begin errors++; $display("FAIL bp_done: %0d pulses, required 1", done_cnt); end
  endtask

  task automatic test_wrap_and_zero;
    mem[16'hFFFF] = 16'($urandom); mem[16'h0000] = 16'($urandom);
    build_expect(16'hFFFF, 2);
    run_dump(16'hFFFF, 16'd2, 100, 0);
    vectors++;
    if (rd_a.size() != 2 || rd_a[0] !== 16'hFFFF || rd_a[1] !== 16'h0000) begin
      errors++; $display("FAIL wrap_addr: got %p, required FFFF,0000", rd_a);
    end
    vectors++;
    if (got_b != exp_b) begin errors++; $display("FAIL wrap_bytes: got %p, required %p", got_b, exp_b); end
    vectors++;
    if (done_cyc != 9) begin errors++; $display("FAIL wrap_done: cycle %0d, required 9", done_cyc); end
    run_dump(16'($urandom), 16'd0, 100, 0);
    vectors++;
    if (first_valid != 0 || rd_a.size() != 0) begin
      errors++; $display("FAIL zero_activity: valid at %0d, %0d reads, required none", first_valid, rd_a.size());
    end
    vectors++;
    if (done_cyc != 1 || done_cnt != 1) begin
      errors++; $display("FAIL zero_done: cycle %0d count %0d, required cycle 1 count 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_abort;
    for (int i = 0; i < 3; i++) mem[16'h0040 + 16'(i)] = 16'($urandom);
    @(posedge clk); #1;
    base_addr = 16'h0040; length = 16'd3; start = 1; tx_ready = 1;
    for (int k = 1; k <= 8; k++) begin @(posedge clk); #1; start = 0; end
    vectors++;
    if (tx_valid !== 1'b1 || tx_data !== mem[16'h0041][7:0]) begin
      errors++; $display("FAIL abort_lo: valid=%b data=%h, required 1/%h", tx_valid, tx_data, mem[16'h0041][7:0]);
    end
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    vectors++;
    if ({mem_addr, mem_en, tx_data, tx_valid, busy, done} !== '0) begin
      errors++; $display("FAIL abort_reset: addr=%h en=%b data=%h valid=%b busy=%b done=%b, required all 0",
                         mem_addr, mem_en, tx_data, tx_valid, busy, done);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL abort_idle step %0d: done=%b busy=%b, required 0/0", k, done, busy);
      end
    end
    tx_ready = 0;
  endtask

  task automatic test_ignored_start;
    for (int i = 0; i < 3; i++) mem[16'h0020 + 16'(i)] = 16'($urandom);
    build_expect(16'h0020, 3);
    run_dump(16'h0020, 16'd3, 80, 6);
    vectors++;
    if (got_b != exp_b) begin errors++; $display("FAIL ignored_bytes: got %p, required %p", got_b, exp_b); end
    vectors++;
    if (rd_a.size() != 3 || rd_a[0] !== 16'h0020 || rd_a[2] !== 16'h0022) begin
      errors++; $display("FAIL ignored_addr: got %p, required 0020..0022", rd_a);
    end
    vectors++;
    if (done_cnt != 1) begin errors++; $display("FAIL ignored_done: %0d pulses, required 1", done_cnt); end
  endtask

  task automatic test_round_trip;
    logic [15:0] base, w, a;
    base = 16'($urandom);
    for (int i = 0; i < 64; i++) mem[base + 16'(i)] = 16'($urandom);
    run_dump(base, 16'd64, 70, 0);
    vectors++;
    if (got_b.size() != 128) begin errors++; $display("FAIL rt_count: got %0d bytes, required 128", got_b.size()); end
    for (int i = 0; i < 64 && 2 * i + 1 < got_b.size(); i++) begin
      w = {got_b[2*i], got_b[2*i+1]};
      a = base + 16'(i);
      vectors++;
      if (w !== mem[a]) begin errors++; $display("FAIL rt_word[%0d]: got %h, required %h", i, w, mem[a]); end
    end
    vectors++;
    if (done_cnt != 1) begin errors++; $display("FAIL rt_done: %0d pulses, required 1", done_cnt); end
  endtask

  initial begin
    test_reset;
    test_single_word;
    test_backpressure;
    test_wrap_and_zero;
    test_abort;
    test_ignored_start;
    test_round_trip;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
